// File: rtl/seg_mux_display_if.sv
// Signal bundle between the datapath result registers and the display driver.
// The master side supplies data/config; the slave side drives the pins.
interface seg_mux_display_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] data_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic                    blank_lz;
  logic [3:0]              brightness;
  logic [6:0]              segment;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   anode;
  logic                    frame_done;

  modport master (
    output data_in, dp_in, load, blank_lz, brightness,
    input  segment, dp_out, anode, frame_done
  );

  modport slave (
    input  data_in, dp_in, load, blank_lz, brightness,
    output segment, dp_out, anode, frame_done
  );
endinterface

// File: rtl/seg_mux_display.sv
// Multiplexed hex seven-segment driver: double-buffered digits, PWM brightness,
// leading-zero suppression, a blank ghosting cycle per slot, selectable pin polarity.
module seg_mux_display #(
  parameter int NUM_DIGITS     = 8,
  parameter int DIV            = 50000,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  seg_mux_display_if.slave   bus
);

  localparam int CW  = $clog2(DIV);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int SUB = DIV / 16;
  localparam int SW  = (SUB > 1) ? $clog2(SUB) : 1;
  localparam int DW  = 4 * NUM_DIGITS;

  localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [SW-1:0]         sub;
  logic [3:0]            phase;
  logic [3:0]            bri_q;
  logic [DW-1:0]         pend_data;
  logic [DW-1:0]         act_data;
  logic [NUM_DIGITS-1:0] pend_dp;
  logic [NUM_DIGITS-1:0] act_dp;

  logic                  tick;
  logic                  frame_end;
  logic                  lit;
  logic                  upper_nz;
  logic                  blank;
  logic [3:0]            nib;
  logic [6:0]            seg_n;
  logic                  dp_n;
  logic [NUM_DIGITS-1:0] an_n;

  assign tick      = (cnt == CW'(DIV - 1));
  assign frame_end = tick && (idx == IW'(NUM_DIGITS - 1));

  function automatic logic [6:0] glyph(input logic [3:0] v);
    logic [6:0] g;
    case (v)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Slot prescaler, digit index and PWM phase (phase == cnt / SUB within a slot)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      idx   <= '0;
      sub   <= '0;
      phase <= '0;
      bri_q <= '0;
    end else begin
      if (tick) begin
        cnt   <= '0;
        sub   <= '0;
        phase <= '0;
        idx   <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
      end else begin
        cnt <= cnt + CW'(1);
        if (sub == SW'(SUB - 1)) begin
          sub   <= '0;
          phase <= phase + 4'd1;
        end else begin
          sub <= sub + SW'(1);
        end
      end
      // The cnt==0 cycle is always dark, so sampling here covers the whole slot
      if (cnt == '0) bri_q <= bus.brightness;
    end
  end

  // Double buffer: active only changes on a frame boundary
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_data <= '0;
      pend_dp   <= '0;
      act_data  <= '0;
      act_dp    <= '0;
    end else begin
      if (frame_end) begin
        act_data <= pend_data;
        act_dp   <= pend_dp;
      end
      if (bus.load) begin
        pend_data <= bus.data_in;
        pend_dp   <= bus.dp_in;
      end
    end
  end

  always_comb begin
    upper_nz = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (i >= int'(idx) && act_data[4*i +: 4] != 4'h0) upper_nz = 1'b1;
    end
    nib   = 4'(act_data >> {idx, 2'b00});
    lit   = (cnt != '0) && (phase <= bri_q);
    blank = bus.blank_lz && (idx != '0) && !upper_nz;
    seg_n = (lit && !blank) ? glyph(nib) : 7'h00;
    dp_n  = lit && act_dp[idx];
    an_n  = lit ? (NUM_DIGITS'(1) << idx) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.segment    <= {7{SEG_INV}};
      bus.dp_out     <= SEG_INV;
      bus.anode      <= {NUM_DIGITS{AN_INV}};
      bus.frame_done <= 1'b0;
    end else begin
      bus.segment    <= seg_n ^ {7{SEG_INV}};
      bus.dp_out     <= dp_n ^ SEG_INV;
      bus.anode      <= an_n ^ {NUM_DIGITS{AN_INV}};
      bus.frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_mux_display.sv
// Randomised and directed bench for seg_mux_display: a position-based reference
// model queues the expected pin state per edge; a monitor pops and compares.
module tb_seg_mux_display;
  localparam int N      = 4;
  localparam int DIV    = 32;
  localparam int PERIOD = N * DIV;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_mux_display_if #(.NUM_DIGITS(N)) bus();

  seg_mux_display #(
    .NUM_DIGITS(N), .DIV(DIV), .AN_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   seg;
    logic         dp;
    logic         fd;
  } obs_t;

  obs_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Model state: p = cycles elapsed since the last reset edge
  int          p = 0;
  int          m_bri = 0;
  logic [15:0] m_pend = '0, m_act = '0;
  logic [3:0]  m_pdp = '0, m_adp = '0;

  task automatic model_step();
    obs_t e;
    int c, d;
    logic lit, blank;
    logic [15:0] upper;
    if (!rst_n) begin
      p = 0; m_bri = 0; m_pend = '0; m_act = '0; m_pdp = '0; m_adp = '0;
      e.an = '1; e.seg = 7'h00; e.dp = 1'b0; e.fd = 1'b0;
    end else begin
      c     = p % DIV;
      d     = (p / DIV) % N;
      lit   = (c != 0) && (c < (m_bri + 1) * DIV / 16);
      upper = m_act >> (4 * d);
      blank = bus.blank_lz && (d != 0) && (upper == 16'h0);
      e.an  = lit ? ~(4'(1) << d) : 4'hF;
      e.seg = (lit && !blank) ? glyph_tab[upper[3:0]] : 7'h00;
      e.dp  = lit && m_adp[d];
      e.fd  = ((p % PERIOD) == PERIOD - 1);
      if (c == 0) m_bri = int'(bus.brightness);
      if ((p % PERIOD) == PERIOD - 1) begin
        m_act = m_pend;
        m_adp = m_pdp;
      end
      if (bus.load) begin
        m_pend = bus.data_in;
        m_pdp  = bus.dp_in;
      end
      p++;
    end
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  obs_t mon_e, mon_a;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {bus.anode, bus.segment, bus.dp_out, bus.frame_done};
      vectors++;
      if (mon_a !== mon_e) begin
        miscompares++;
        if (miscompares <= 20)
          $display("FAIL pins t=%0t actual an=%b seg=%h dp=%b fd=%b required an=%b seg=%h dp=%b fd=%b",
                   $time, mon_a.an, mon_a.seg, mon_a.dp, mon_a.fd,
                   mon_e.an, mon_e.seg, mon_e.dp, mon_e.fd);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int target);
    int k = 0;
    while ((p % PERIOD) != target && k < 2 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    if (k >= 2 * PERIOD) begin
      miscompares++;
      $display("FAIL wait_pos actual timeout required position %0d", target);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    bus.data_in = d;
    bus.dp_in   = dp;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  // Over any full frame window the lit count is N*((bri+1)*DIV/16-1) and frame_done fires once
  task automatic check_window(input int exp_lit, input string name);
    int lit_n = 0;
    int fd_n = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (bus.anode !== 4'hF) lit_n++;
      if (bus.frame_done === 1'b1) fd_n++;
    end
    vectors++;
    if (lit_n != exp_lit || fd_n != 1) begin
      miscompares++;
      $display("FAIL %s actual lit=%0d fd=%0d required lit=%0d fd=1", name, lit_n, fd_n, exp_lit);
    end
  endtask

  initial begin
    bus.data_in    = '0;
    bus.dp_in      = '0;
    bus.load       = 1'b0;
    bus.blank_lz   = 1'b0;
    bus.brightness = 4'd15;
    rst_n          = 1'b0;
    cyc(3);
    rst_n = 1'b1;

    cyc(2 * PERIOD + 40);
    check_window(4 * 31, "idle_bri15");

    wait_pos(50);
    do_load(16'hA5F0, 4'b0100);
    cyc(2 * PERIOD);

    bus.blank_lz = 1'b1;
    do_load(16'h0030, 4'b0000);
    cyc(2 * PERIOD);
    do_load(16'h0000, 4'b0000);
    cyc(2 * PERIOD);
    bus.blank_lz = 1'b0;

    bus.brightness = 4'd3;
    cyc(2 * PERIOD);
    check_window(4 * 7, "bri3");
    bus.brightness = 4'd15;
    cyc(2 * PERIOD);
    check_window(4 * 31, "bri15");

    do_load(16'h9876, 4'b0001);
    wait_pos(PERIOD - 1);
    do_load(16'h1234, 4'b1000);
    cyc(3 * PERIOD);

    wait_pos(2 * DIV + 10);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2 * PERIOD);

    for (int i = 0; i < 3000; i++) begin
      bus.load    = ($urandom_range(0, 15) == 0);
      bus.data_in = 16'($urandom);
      bus.dp_in   = 4'($urandom);
      if ($urandom_range(0, 99) == 0) bus.blank_lz = 1'($urandom);
      if ($urandom_range(0, 59) == 0) bus.brightness = 4'($urandom);
      rst_n = ($urandom_range(0, 599) != 0);
      @(negedge clk);
    end
    bus.load = 1'b0;
    rst_n    = 1'b1;
    cyc(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
